frame_reader: RTL

//  Read-back side of the fill path. Fetches a rectangle of 24-bit pixels from frame SRAM in 64-word bursts.
//  The fill block writes that SRAM; this block only reads it.

---
 rtl/fill_pkg.sv | 42 ++++
 rtl/frame_reader_if.sv | 38 +++
 rtl/frame_reader_burst_shifter.sv | 62 ++++++
 rtl/frame_reader.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/fill_pkg.sv
// Shared definitions for the fill / read-back path: frame geometry,
// burst sizing, rectangle coordinates and the reader state encoding.
package fill_pkg;

    localparam int ADDR_W      = 24;
    localparam int WORD_W      = 24;
    localparam int BURST_WORDS = 64;
    localparam int FRAME_W     = 640;
    localparam int MEM_LAT     = 1;

    localparam int COORD_W     = 12;
    // One extra bit so that x2=4095 plus one still compares correctly.
    localparam int CNT_W       = COORD_W + 1;
    localparam int N_W         = $clog2(BURST_WORDS + 1);
    localparam int LAT_W       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int BURST_BITS  = BURST_WORDS * WORD_W;
    localparam int PROD_W      = ADDR_W + 12;

    // Inclusive rectangle corners; x1 sits in the most significant field.
    typedef struct packed {
        logic [COORD_W-1:0] x1;
        logic [COORD_W-1:0] y1;
        logic [COORD_W-1:0] x2;
        logic [COORD_W-1:0] y2;
    } coord_t;

    typedef enum logic [2:0] {
        RD_IDLE   = 3'd0,
        RD_REQ    = 3'd1,
        RD_WAIT   = 3'd2,
        RD_STREAM = 3'd3,
        RD_FIN    = 3'd4
    } rd_state_t;

    // Word address of pixel (x,y); the product is formed wide and then
    // truncated so the address wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [CNT_W-1:0] x,
                                                   input logic [CNT_W-1:0] y);
        return ADDR_W'(PROD_W'(y) * PROD_W'(FRAME_W) + PROD_W'(x));
    endfunction

endpackage

// File: rtl/frame_reader_if.sv
// Bundle of the frame reader's control, SRAM and pixel-stream signals.
// Pixel stream: a word transfers on a clock edge where pix_valid and
// pix_ready are both high; while pix_valid is high and pix_ready low the
// producer holds pix_data/pix_sol/pix_eof stable and keeps pix_valid high.
interface frame_reader_if;
    import fill_pkg::*;

    logic                   start;
    logic [4*COORD_W-1:0]   coordinates;
    logic                   fill_busy;
    logic                   mem_read_en;
    logic [ADDR_W-1:0]      mem_addr;
    logic [BURST_BITS-1:0]  mem_read_data;
    logic [WORD_W-1:0]      pix_data;
    logic                   pix_valid;
    logic                   pix_ready;
    logic                   pix_sol;
    logic                   pix_eof;
    logic                   busy;
    logic                   done;
    logic                   err;
    rd_state_t              dbg_state;

    // Reader side.
    modport master (
        input  start, coordinates, fill_busy, mem_read_data, pix_ready,
        output mem_read_en, mem_addr, pix_data, pix_valid, pix_sol, pix_eof,
               busy, done, err, dbg_state
    );

    // Environment side: controller, SRAM and pixel sink.
    modport slave (
        output start, coordinates, fill_busy, mem_read_data, pix_ready,
        input  mem_read_en, mem_addr, pix_data, pix_valid, pix_sol, pix_eof,
               busy, done, err, dbg_state
    );

endinterface

// File: rtl/frame_reader_burst_shifter.sv
// Holds one SRAM burst and hands its first n words out one per handshake.
module burst_shifter
    import fill_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [N_W-1:0]        n,
    input  logic [BURST_BITS-1:0] burst,
    output logic [WORD_W-1:0]     out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_first,
    output logic                  out_last
);

    logic [BURST_BITS-1:0] buf_q, buf_d;
    logic [N_W-1:0]        idx_q, idx_d;
    logic [N_W-1:0]        n_q, n_d;
    logic                  valid_q, valid_d;

    // Load a new burst or step to the next word on each accepted transfer.
    always_comb begin
        buf_d   = buf_q;
        idx_d   = idx_q;
        n_d     = n_q;
        valid_d = valid_q;
        if (load) begin
            buf_d   = burst;
            idx_d   = '0;
            n_d     = n;
            valid_d = (n != '0);
        end else if (valid_q && out_ready) begin
            if (out_last) begin
                valid_d = 1'b0;
            end else begin
                idx_d = idx_q + N_W'(1);
            end
        end
    end

    // Burst buffer and read pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q   <= '0;
            idx_q   <= '0;
            n_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = buf_q[int'(idx_q) * WORD_W +: WORD_W];
    assign out_valid = valid_q;
    assign out_first = valid_q && (idx_q == '0);
    assign out_last  = valid_q && (idx_q == n_q - N_W'(1));

endmodule

// File: rtl/frame_reader.sv
// Reads a rectangle out of frame SRAM in bursts and streams it in raster
// order. Requests are held off while the fill block owns the SRAM.
module frame_reader
    import fill_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    frame_reader_if.master bus
);

    rd_state_t        state_q, state_d;
    coord_t           coord_q, coord_d, coord_in;
    logic [CNT_W-1:0] cur_x_q, cur_x_d;
    logic [CNT_W-1:0] cur_y_q, cur_y_d;
    logic [N_W-1:0]   n_q, n_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic             err_q, err_d;

    logic [CNT_W-1:0] x1_w, x2_w, y2_w;
    logic [CNT_W-1:0] rem, next_x, next_y;
    logic [N_W-1:0]   n_calc;
    logic             rd_fire, sh_load;
    logic             sh_valid, sh_first, sh_last, sh_hs;
    logic [WORD_W-1:0] sh_data;

    assign coord_in = coord_t'(bus.coordinates);
    assign x1_w     = {1'b0, coord_q.x1};
    assign x2_w     = {1'b0, coord_q.x2};
    assign y2_w     = {1'b0, coord_q.y2};

    // Burst length is clipped at the row end so a burst never spans rows.
    assign rem     = x2_w - cur_x_q + CNT_W'(1);
    assign n_calc  = (rem > CNT_W'(BURST_WORDS)) ? N_W'(BURST_WORDS) : N_W'(rem);
    assign next_x  = cur_x_q + CNT_W'(n_q);
    assign next_y  = cur_y_q + CNT_W'(1);
    assign rd_fire = (state_q == RD_REQ) && !bus.fill_busy;
    assign sh_hs   = sh_valid && bus.pix_ready;

    // Next-state logic: request, wait for SRAM, stream, advance position.
    always_comb begin
        state_d = state_q;
        coord_d = coord_q;
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        n_d     = n_q;
        lat_d   = lat_q;
        err_d   = err_q;
        sh_load = 1'b0;
        case (state_q)
            RD_IDLE: begin
                if (bus.start) begin
                    coord_d = coord_in;
                    cur_x_d = {1'b0, coord_in.x1};
                    cur_y_d = {1'b0, coord_in.y1};
                    err_d   = 1'b0;
                    if ((coord_in.x1 > coord_in.x2) || (coord_in.y1 > coord_in.y2)) begin
                        err_d   = 1'b1;
                        state_d = RD_FIN;
                    end else begin
                        state_d = RD_REQ;
                    end
                end
            end
            RD_REQ: begin
                if (rd_fire) begin
                    lat_d   = '0;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (lat_q == LAT_W'(MEM_LAT - 1)) begin
                    sh_load = 1'b1;
                    n_d     = n_calc;
                    state_d = RD_STREAM;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            RD_STREAM: begin
                if (sh_hs && sh_last) begin
                    if (next_x > x2_w) begin
                        cur_x_d = x1_w;
                        cur_y_d = next_y;
                        state_d = (next_y > y2_w) ? RD_FIN : RD_REQ;
                    end else begin
                        cur_x_d = next_x;
                        state_d = RD_REQ;
                    end
                end
            end
            RD_FIN: begin
                state_d = RD_IDLE;
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase
    end

    // State, position counters and latched rectangle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RD_IDLE;
            coord_q <= '0;
            cur_x_q <= '0;
            cur_y_q <= '0;
            n_q     <= '0;
            lat_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            coord_q <= coord_d;
            cur_x_q <= cur_x_d;
            cur_y_q <= cur_y_d;
            n_q     <= n_d;
            lat_q   <= lat_d;
            err_q   <= err_d;
        end
    end

    burst_shifter u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (sh_load),
        .n         (n_calc),
        .burst     (bus.mem_read_data),
        .out_data  (sh_data),
        .out_valid (sh_valid),
        .out_ready (bus.pix_ready),
        .out_first (sh_first),
        .out_last  (sh_last)
    );

    assign bus.mem_read_en = rd_fire;
    assign bus.mem_addr    = pix_addr(cur_x_q, cur_y_q);
    assign bus.pix_data    = sh_data;
    assign bus.pix_valid   = sh_valid;
    assign bus.pix_sol     = sh_first && (cur_x_q == x1_w);
    assign bus.pix_eof     = sh_last && (next_x > x2_w) && (cur_y_q == y2_w);
    assign bus.busy        = (state_q == RD_REQ) || (state_q == RD_WAIT) ||
                             (state_q == RD_STREAM);
    assign bus.done        = (state_q == RD_FIN);
    assign bus.err         = err_q;
    assign bus.dbg_state   = state_q;

endmodule
